mask_word_writer: RTL and testbench

Consumer end of the mask pixel stream: accepts the per-pixel `valid`/`mask`/`mask_x`/`mask_y` stream from the mask generator and packs 16 mask bits into one word. It buffers packed words in a small FIFO and writes them to frame memory over a req/ack port. It sits between the mask generator and the memory arbiter, in the `clk_25` domain. It also flags frame completion and FIFO overflow.

---
 rtl/mask_pkg.sv | 22 ++
 rtl/mask_word_writer_if.sv | 26 ++
 rtl/mask_word_fifo.sv | 53 +++++
 rtl/mask_word_writer.sv | 198 +++++++++++++++++++
 tb/tb_mask_word_writer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_pkg.sv
// Shared constants and the packed-word FIFO entry type for the mask word writer.
// Defaults describe a 640x480 frame packed 16 mask bits per word.
package mask_pkg;

   localparam int H_ACTIVE_DEF   = 640;
   localparam int V_ACTIVE_DEF   = 480;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int MASK_ADDR_W    = 15;

   function automatic int last_word_addr(input int h_active, input int v_active);
      return h_active * v_active / 16 - 1;
   endfunction

   localparam int WORDS_PER_LINE = H_ACTIVE_DEF / 16;
   localparam int LAST_WORD_ADDR = last_word_addr(H_ACTIVE_DEF, V_ACTIVE_DEF);

   typedef struct packed {
      logic [MASK_ADDR_W-1:0] addr;
      logic [15:0]            data;
   } fifo_entry_t;

endpackage

// File: rtl/mask_word_writer_if.sv
// Pixel stream from the mask generator plus the req/ack word-write port to memory.
// master = stream source / memory side, slave = the writer.
interface mask_word_writer_if #(
   parameter int ADDR_W = mask_pkg::MASK_ADDR_W
) ();

   logic              valid;
   logic              mask;
   logic [9:0]        mask_x;
   logic [9:0]        mask_y;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              wr_ack;

   modport master (
      output valid, mask, mask_x, mask_y, wr_ack,
      input  wr_req, wr_addr, wr_data
   );

   modport slave (
      input  valid, mask, mask_x, mask_y, wr_ack,
      output wr_req, wr_addr, wr_data
   );

endinterface

// File: rtl/mask_word_fifo.sv
// Small synchronous FIFO of packed words; the head is read combinationally from storage.
// DEPTH must be a power of two, at least 2.
module mask_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 31
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Extra pointer bit separates full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
   assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
      end
   end

   assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/mask_word_writer.sv
// Packs the mask pixel stream into 16-bit words and writes them to frame memory via req/ack.
// Define MASK_WRITER_STATS_EN to count foreground pixels per frame on fg_count.
module mask_word_writer
   import mask_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_W     = MASK_ADDR_W
) (
   input  logic              clk_25,
   input  logic              rst_n,
   mask_word_writer_if.slave bus,
   output logic              overflow,
   output logic              frame_done,
   output logic [18:0]       fg_count
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } entry_t;

   localparam int                LINE_WORDS = H_ACTIVE / 16;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(last_word_addr(H_ACTIVE, V_ACTIVE));

   logic              open_q, open_d;
   logic [ADDR_W-1:0] word_addr_q, word_addr_d;
   logic [15:0]       word_data_q, word_data_d;
   logic              pend_q, pend_d;
   entry_t            pend_entry_q, pend_entry_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;

   logic              accept, frame_start, closes, same_word;
   logic [ADDR_W-1:0] pix_addr;
   logic [3:0]        bit_idx;
   logic [15:0]       new_data;

   logic              emit_a_valid, emit_b_valid, lost_word;
   entry_t            emit_a, emit_b;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   entry_t            push_entry, fifo_head;

   assign accept      = bus.valid && (32'(bus.mask_x) < H_ACTIVE) && (32'(bus.mask_y) < V_ACTIVE);
   assign frame_start = accept && (bus.mask_x == '0) && (bus.mask_y == '0);
   assign bit_idx     = bus.mask_x[3:0];
   assign pix_addr    = ADDR_W'(bus.mask_y) * ADDR_W'(LINE_WORDS) + ADDR_W'(bus.mask_x[9:4]);
   assign closes      = (bit_idx == 4'hF) || (32'(bus.mask_x) == H_ACTIVE - 1);
   assign same_word   = open_q && (word_addr_q == pix_addr);

   always_comb begin
      new_data          = same_word ? word_data_q : 16'hFFFF;
      new_data[bit_idx] = bus.mask;
   end

   // Up to two words leave the open register per pixel: a flushed old word, then the new one.
   always_comb begin
      open_d       = open_q;
      word_addr_d  = word_addr_q;
      word_data_d  = word_data_q;
      emit_a_valid = 1'b0;
      emit_a       = '0;
      emit_b_valid = 1'b0;
      emit_b       = '0;
      if (accept) begin
         if (open_q && !same_word) begin
            emit_a_valid = 1'b1;
            emit_a       = '{addr: word_addr_q, data: word_data_q};
         end
         if (closes) begin
            if (emit_a_valid) begin
               emit_b_valid = 1'b1;
               emit_b       = '{addr: pix_addr, data: new_data};
            end else begin
               emit_a_valid = 1'b1;
               emit_a       = '{addr: pix_addr, data: new_data};
            end
            open_d      = 1'b0;
            word_data_d = 16'hFFFF;
         end else begin
            open_d      = 1'b1;
            word_addr_d = pix_addr;
            word_data_d = new_data;
         end
      end
   end

   // A parked word owns the FIFO write port; a second word that cannot be parked is dropped.
   always_comb begin
      fifo_push    = 1'b0;
      push_entry   = emit_a;
      pend_d       = 1'b0;
      pend_entry_d = pend_entry_q;
      lost_word    = 1'b0;
      if (pend_q) begin
         fifo_push  = 1'b1;
         push_entry = pend_entry_q;
         pend_d     = emit_a_valid;
         if (emit_a_valid) begin
            pend_entry_d = emit_a;
         end
         lost_word  = emit_b_valid;
      end else begin
         fifo_push  = emit_a_valid;
         push_entry = emit_a;
         pend_d     = emit_b_valid;
         if (emit_b_valid) begin
            pend_entry_d = emit_b;
         end
      end
   end

   assign fifo_pop = !fifo_empty && bus.wr_ack;

   always_comb begin
      overflow_d = overflow_q;
      if (frame_start) begin
         overflow_d = 1'b0;
      end
      if ((fifo_push && fifo_full && !fifo_pop) || lost_word) begin
         overflow_d = 1'b1;
      end
      frame_done_d = fifo_pop && (fifo_head.addr == LAST_ADDR);
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         open_q       <= 1'b0;
         word_addr_q  <= '0;
         word_data_q  <= 16'hFFFF;
         pend_q       <= 1'b0;
         pend_entry_q <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         open_q       <= open_d;
         word_addr_q  <= word_addr_d;
         word_data_q  <= word_data_d;
         pend_q       <= pend_d;
         pend_entry_q <= pend_entry_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   mask_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + 16)
   ) u_fifo (
      .clk_i   (clk_25),
      .rst_ni  (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign bus.wr_req  = !fifo_empty;
   assign bus.wr_addr = fifo_empty ? '0 : fifo_head.addr;
   assign bus.wr_data = fifo_empty ? 16'hFFFF : fifo_head.data;
   assign overflow    = overflow_q;
   assign frame_done  = frame_done_q;

`ifdef MASK_WRITER_STATS_EN
   logic [18:0] fg_cnt_q, fg_cnt_d;
   logic [18:0] fg_count_q, fg_count_d;

   // The frame-start pixel itself is counted after the clear.
   always_comb begin
      fg_cnt_d = fg_cnt_q;
      if (frame_start) begin
         fg_cnt_d = {18'd0, !bus.mask};
      end else if (accept && !bus.mask && (fg_cnt_q != '1)) begin
         fg_cnt_d = fg_cnt_q + 19'd1;
      end
      fg_count_d = frame_done_d ? fg_cnt_q : fg_count_q;
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         fg_cnt_q   <= '0;
         fg_count_q <= '0;
      end else begin
         fg_cnt_q   <= fg_cnt_d;
         fg_count_q <= fg_count_d;
      end
   end

   assign fg_count = fg_count_q;
`else
   assign fg_count = '0;
`endif

endmodule

// File: tb/tb_mask_word_writer.sv
// Directed and randomized bench for mask_word_writer against a word-packing reference model.
// Expected fg_count follows MASK_WRITER_STATS_EN.
module tb_mask_word_writer;
   import mask_pkg::*;

   logic        clk_25 = 1'b0;
   logic        rst_n  = 1'b1;
   logic        overflow, frame_done;
   logic [18:0] fg_count;

   mask_word_writer_if #(.ADDR_W(MASK_ADDR_W)) bus ();

   mask_word_writer #(
      .H_ACTIVE   (640),
      .V_ACTIVE   (480),
      .FIFO_DEPTH (4),
      .ADDR_W     (MASK_ADDR_W)
   ) dut (
      .clk_25     (clk_25),
      .rst_n      (rst_n),
      .bus        (bus),
      .overflow   (overflow),
      .frame_done (frame_done),
      .fg_count   (fg_count)
   );

   always #20 clk_25 = ~clk_25;

   int          checks = 0;
   int          errors = 0;
   fifo_entry_t got_q[$];
   fifo_entry_t exp_q[$];
   int          got_base = 0;
   int          fd_pulses = 0;
   int          fd_bad = 0;
   bit          last_pop = 1'b0;
   bit          gap_en = 1'b0;
   bit          m_open;
   int          m_addr;
   logic [15:0] m_data;

   // Record every accepted write and every frame_done pulse.
   always @(negedge clk_25) begin
      if (frame_done) begin
         fd_pulses++;
         if (!last_pop) fd_bad++;
      end
      last_pop = 1'b0;
      if (rst_n && bus.wr_req && bus.wr_ack) begin
         got_q.push_back(fifo_entry_t'{addr: bus.wr_addr, data: bus.wr_data});
         last_pop = (int'(bus.wr_addr) == LAST_WORD_ADDR);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_25);
      #1;
   endtask

   task automatic sample;
      @(negedge clk_25);
      #1;
   endtask

   function automatic fifo_entry_t mk(input int a, input logic [15:0] d);
      fifo_entry_t e;
      e.addr = MASK_ADDR_W'(a);
      e.data = d;
      return e;
   endfunction

   task automatic model_reset;
      m_open = 1'b0;
      m_addr = 0;
      m_data = 16'hFFFF;
      exp_q.delete();
   endtask

   // Reference: a word is the 16 pixels x/16 of a line; it leaves when its last column is
   // written, the line ends, or a pixel of another word arrives first.
   task automatic model_pixel(input int x, input int y, input bit m, output bit dbl);
      bit flushed;
      int a;
      dbl     = 1'b0;
      flushed = 1'b0;
      if (x >= 640 || y >= 480) return;
      a = y * 40 + x / 16;
      if (m_open && a != m_addr) begin
         exp_q.push_back(mk(m_addr, m_data));
         m_open  = 1'b0;
         flushed = 1'b1;
      end
      if (!m_open) begin
         m_open = 1'b1;
         m_addr = a;
         m_data = 16'hFFFF;
      end
      m_data[x % 16] = m;
      if (x % 16 == 15 || x == 639) begin
         exp_q.push_back(mk(m_addr, m_data));
         m_open = 1'b0;
         dbl    = flushed;
      end
   endtask

   task automatic pix(input int x, input int y, input bit m);
      bit dbl;
      bus.valid  = 1'b1;
      bus.mask   = m;
      bus.mask_x = 10'(x);
      bus.mask_y = 10'(y);
      model_pixel(x, y, m, dbl);
      tick;
      bus.valid = 1'b0;
      if (dbl && gap_en) tick;
   endtask

   task automatic do_reset;
      bus.valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      model_reset;
      got_base = got_q.size();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (((got_q.size() - got_base) < exp_q.size() || bus.wr_req) && n < 300) begin
         sample;
         n++;
      end
      chk({tag, " drain_timeout"}, 32'(n < 300), 32'd1);
      chk({tag, " count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (got_base + i < got_q.size()) begin
            $display("%s write %0d addr %0d data %h", tag, i, got_q[got_base+i].addr, got_q[got_base+i].data);
            chk({tag, " addr"}, 32'(got_q[got_base+i].addr), 32'(exp_q[i].addr));
            chk({tag, " data"}, 32'(got_q[got_base+i].data), 32'(exp_q[i].data));
         end
      end
   endtask

   initial begin
      int x, y, lastx, fd_base;
      bus.valid  = 1'b0;
      bus.mask   = 1'b0;
      bus.mask_x = '0;
      bus.mask_y = '0;
      bus.wr_ack = 1'b0;
      model_reset;
      #5 rst_n = 1'b0;
      sample;
      chk("rst wr_req", 32'(bus.wr_req), 32'd0);
      chk("rst wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst wr_data", 32'(bus.wr_data), 32'hFFFF);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      chk("rst fg_count", 32'(fg_count), 32'd0);
      tick;
      rst_n = 1'b1;
      tick;

      // Full line 0 with alternating mask, memory always ready.
      bus.wr_ack = 1'b1;
      got_base = got_q.size();
      for (int i = 0; i < 640; i++) pix(i, 0, (i % 2 == 0));
      drain("line0");
      chk("line0 writes", 32'(got_q.size() - got_base), 32'd40);
      for (int i = 0; i < 40; i++) begin
         if (got_base + i < got_q.size()) begin
            chk("line0 addr", 32'(got_q[got_base+i].addr), 32'(i));
            chk("line0 data", 32'(got_q[got_base+i].data), 32'h5555);
         end
      end
      chk("line0 overflow", 32'(overflow), 32'd0);

      // Address change flushes the partial word.
      do_reset;
      pix(3, 2, 1'b0);
      pix(20, 2, 1'b1);
      repeat (4) sample;
      chk("flush count", 32'(got_q.size() - got_base), 32'd1);
      if (got_q.size() > got_base) begin
         $display("flush write addr %0d data %h", got_q[got_base].addr, got_q[got_base].data);
         chk("flush addr", 32'(got_q[got_base].addr), 32'd80);
         chk("flush data", 32'(got_q[got_base].data), 32'hFFF7);
      end
      chk("flush open word held", 32'(bus.wr_req), 32'd0);

      // Double close: flushed word first, then the closing word one cycle later.
      do_reset;
      pix(5, 0, 1'b0);
      pix(31, 0, 1'b0);
      sample;
      chk("dbl req1", 32'(bus.wr_req), 32'd1);
      chk("dbl addr1", 32'(bus.wr_addr), 32'd0);
      chk("dbl data1", 32'(bus.wr_data), 32'hFFDF);
      sample;
      chk("dbl req2", 32'(bus.wr_req), 32'd1);
      chk("dbl addr2", 32'(bus.wr_addr), 32'd1);
      chk("dbl data2", 32'(bus.wr_data), 32'h7FFF);
      sample;
      chk("dbl idle", 32'(bus.wr_req), 32'd0);

      // Six words with memory stalled: four held, overflow sticky until frame start.
      do_reset;
      bus.wr_ack = 1'b0;
      for (int i = 3; i <= 8; i++) pix(15, i, 1'b0);
      sample;
      chk("ovf req", 32'(bus.wr_req), 32'd1);
      chk("ovf flag", 32'(overflow), 32'd1);
      chk("ovf head", 32'(bus.wr_addr), 32'd120);
      repeat (3) sample;
      chk("ovf head stable", 32'(bus.wr_addr), 32'd120);
      chk("ovf data stable", 32'(bus.wr_data), 32'h7FFF);
      tick;
      bus.wr_ack = 1'b1;
      repeat (6) sample;
      chk("ovf writes", 32'(got_q.size() - got_base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (got_base + i < got_q.size()) begin
            $display("ovf write %0d addr %0d data %h", i, got_q[got_base+i].addr, got_q[got_base+i].data);
            chk("ovf addr", 32'(got_q[got_base+i].addr), 32'(120 + 40 * i));
            chk("ovf data", 32'(got_q[got_base+i].data), 32'h7FFF);
         end
      end
      chk("ovf sticky", 32'(overflow), 32'd1);
      pix(0, 0, 1'b1);
      sample;
      chk("ovf cleared", 32'(overflow), 32'd0);

      // Reset while three words are queued.
      do_reset;
      bus.wr_ack = 1'b0;
      for (int i = 1; i <= 3; i++) pix(15, i, 1'b0);
      sample;
      chk("rst2 pre req", 32'(bus.wr_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst2 wr_req", 32'(bus.wr_req), 32'd0);
      chk("rst2 wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst2 wr_data", 32'(bus.wr_data), 32'hFFFF);
      chk("rst2 overflow", 32'(overflow), 32'd0);
      chk("rst2 frame_done", 32'(frame_done), 32'd0);
      chk("rst2 fg_count", 32'(fg_count), 32'd0);
      tick;
      rst_n = 1'b1;
      bus.wr_ack = 1'b1;
      repeat (5) sample;
      chk("rst2 no req", 32'(bus.wr_req), 32'd0);
      chk("rst2 no writes", 32'(got_q.size() - got_base), 32'd0);
      model_reset;

      // Random runs of pixels, including off-frame coordinates.
      do_reset;
      gap_en = 1'b1;
      lastx = 0;
      y = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) x = (lastx + 1) % 660;
         else x = $urandom_range(0, 700);
         if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 9) == 0) ? 490 : $urandom_range(0, 3);
         lastx = x;
         if ($urandom_range(0, 4) == 0) tick;
         pix(x, y, 1'($urandom_range(0, 1)));
      end
      drain("rand");
      chk("rand overflow", 32'(overflow), 32'd0);

      // Sparse full frame of 100 foreground pixels ending at the last pixel.
      do_reset;
      fd_base = fd_pulses;
      pix(0, 0, 1'b0);
      for (int i = 0; i < 98; i++) pix($urandom_range(0, 639), $urandom_range(1, 478), 1'b0);
      pix(639, 479, 1'b0);
      drain("frame");
      repeat (2) sample;
      chk("frame_done pulses", 32'(fd_pulses - fd_base), 32'd1);
      chk("frame_done timing", 32'(fd_bad), 32'd0);
      chk("frame overflow", 32'(overflow), 32'd0);
`ifdef MASK_WRITER_STATS_EN
      chk("fg_count", 32'(fg_count), 32'd100);
`else
      chk("fg_count", 32'(fg_count), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
